// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between fetch (IF) and memory stage (MEM).
// Optional IF anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int W          = 16,
    parameter int AW         = 11,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [W-1:0]  if_addr,
    output logic [W-1:0]  if_rdata,
    output logic          if_ready,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [W-1:0]  mem_addr,
    input  logic [W-1:0]  mem_wdata,
    output logic [W-1:0]  mem_rdata,
    output logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          ram_re,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [W-1:0]  ram_wdata,
    input  logic [W-1:0]  ram_rdata
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state_reg, state_next;
    logic            gnt_mem_reg;
    logic            we_reg;
    logic [WCW-1:0]  wait_cnt_reg;
    logic [AW-1:0]   ram_addr_reg;
    logic [W-1:0]    ram_wdata_reg;
    logic [W-1:0]    if_rdata_reg;
    logic [W-1:0]    mem_rdata_reg;

    logic pick_mem, pick_if, grant, wait_last;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);
    logic [SCW-1:0] starve_cnt_reg;
    logic           starve_hit;

    assign starve_hit = (starve_cnt_reg >= SCW'(STARVE_MAX));
    assign pick_if    = if_req & (~mem_req | starve_hit);
    assign pick_mem   = mem_req & ~pick_if;

    // Counts MEM grants taken while IF waits; any IF grant or idle IF clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
        end else if (!if_req || (grant && pick_if)) begin
            starve_cnt_reg <= '0;
        end else if (grant && pick_mem && !starve_hit) begin
            starve_cnt_reg <= starve_cnt_reg + SCW'(1);
        end
    end
`else
    assign pick_mem = mem_req;
    assign pick_if  = if_req & ~mem_req;
`endif

    assign grant     = (state_reg == IDLE) && (pick_mem || pick_if);
    assign wait_last = (state_reg == WAIT) && (wait_cnt_reg == WCW'(RD_LAT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = we_reg ? DONE : WAIT;
            WAIT:    if (wait_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_re    = (state_reg == ISSUE) && !we_reg;
        ram_we    = (state_reg == ISSUE) && we_reg;
        mem_ready = (state_reg == DONE) && gnt_mem_reg;
        if_ready  = (state_reg == DONE) && !gnt_mem_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_mem_reg   <= 1'b0;
            we_reg        <= 1'b0;
            wait_cnt_reg  <= '0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
        end else begin
            if (grant) begin
                gnt_mem_reg   <= pick_mem;
                we_reg        <= pick_mem & mem_we;
                ram_addr_reg  <= pick_mem ? mem_addr[AW-1:0] : if_addr[AW-1:0];
                ram_wdata_reg <= mem_wdata;
            end
            if (state_reg == ISSUE) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + WCW'(1);
            end
            // Read data lands RD_LAT cycles after the strobe, i.e. on the last WAIT cycle.
            if (wait_last) begin
                if (gnt_mem_reg) mem_rdata_reg <= ram_rdata;
                else             if_rdata_reg  <= ram_rdata;
            end
        end
    end

    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM (RD_LAT=1).
// Define MEM_ARB_STARVE_GUARD_EN for both files to check the starvation guard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_re;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;

    logic [15:0] ram [0:2047];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] last_if  = '0;
    logic [15:0] last_mem = '0;

    mem_port_arbiter #(.W(16), .AW(11), .RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [10:0] exp_ram_addr;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, strobes = 0, strobe_cyc = -1;
        bit got = 0, strobe_we = 0;
        logic [10:0] s_addr = '0;
        logic [15:0] s_wdata = '0;
        @(negedge clk);
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk("stall_c0", v.is_mem ? stall_mem : stall_if, 1);
        while (!got && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (ram_re || ram_we) begin
                strobes++;
                if (strobe_cyc < 0) begin
                    strobe_cyc = cyc; s_addr = ram_addr; s_wdata = ram_wdata; strobe_we = ram_we;
                end
            end
            if (ram_re && ram_we) chk("both_strobes", 1, 0);
            if ((v.is_mem ? mem_ready : if_ready) == 1'b1) begin
                got = 1;
                if (!v.we) chk("rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
                chk("other_rdata_hold", v.is_mem ? if_rdata : mem_rdata, v.is_mem ? last_if : last_mem);
                if (!v.we) begin
                    if (v.is_mem) last_mem = v.exp_rdata;
                    else          last_if  = v.exp_rdata;
                end
                mem_req = 1'b0; if_req = 1'b0;
            end else begin
                if ((v.is_mem ? stall_mem : stall_if) !== 1'b1) chk("stall_mid", 0, 1);
            end
        end
        chk("ready_seen", got, 1);
        chk("latency", cyc, v.exp_lat);
        chk("strobe_count", strobes, 1);
        chk("strobe_cycle", strobe_cyc, 1);
        chk("strobe_kind", strobe_we, v.we);
        chk("ram_addr", s_addr, v.exp_ram_addr);
        if (v.we) chk("ram_wdata", s_wdata, v.wdata);
        #1;
        chk("stall_after", {stall_if, stall_mem}, 0);
        $display("txn %0d: %s %s addr=0x%04h lat=%0d rdata=0x%04h", idx,
                 v.is_mem ? "MEM" : "IF ", v.we ? "WR" : "RD", v.addr, cyc,
                 v.is_mem ? mem_rdata : if_rdata);
    endtask

    initial begin
        int mem_cnt, if_cnt, mem_rdy_cyc, if_re_cyc, if_rdy_cyc;
        vecs[0] = '{1, 1, 16'h0010, 16'hABCD, 16'h0000, 11'h010, 2};
        vecs[1] = '{0, 0, 16'h0010, 16'h0000, 16'hABCD, 11'h010, 3};
        vecs[2] = '{1, 1, 16'h07FF, 16'h1234, 16'h0000, 11'h7FF, 2};
        vecs[3] = '{1, 0, 16'h07FF, 16'h0000, 16'h1234, 11'h7FF, 3};
        vecs[4] = '{1, 1, 16'h0005, 16'h5A5A, 16'h0000, 11'h005, 2};
        vecs[5] = '{1, 0, 16'hF805, 16'h0000, 16'h5A5A, 11'h005, 3};
        vecs[6] = '{0, 0, 16'hFFFF, 16'h0000, 16'h1234, 11'h7FF, 3};
        vecs[7] = '{1, 1, 16'h8005, 16'hBEEF, 16'h0000, 11'h005, 2};
        vecs[8] = '{0, 0, 16'h0005, 16'h0000, 16'hBEEF, 11'h005, 3};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {if_ready, mem_ready, ram_re, ram_we, if_rdata, mem_rdata, ram_addr, ram_wdata}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {if_ready, mem_ready, ram_re, ram_we, stall_if, stall_mem}, 0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Simultaneous requests: MEM first, IF right after MEM's DONE
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h07FF;
        if_req = 1'b1; if_addr = 16'h0010;
        mem_rdy_cyc = -1; if_re_cyc = -1; if_rdy_cyc = -1;
        for (int c = 1; c <= 20 && if_rdy_cyc < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready && mem_rdy_cyc < 0) begin
                mem_rdy_cyc = c;
                chk("conc_mem_rdata", mem_rdata, 16'h1234);
                mem_req = 1'b0;
            end
            if (ram_re && mem_rdy_cyc > 0 && if_re_cyc < 0) begin
                if_re_cyc = c;
                chk("conc_if_addr", ram_addr, 11'h010);
            end
            if (if_ready) begin
                if_rdy_cyc = c;
                chk("conc_if_rdata", if_rdata, 16'hABCD);
                if_req = 1'b0;
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
        chk("conc_mem_ready_cyc", mem_rdy_cyc, 3);
        chk("conc_if_re_cyc", if_re_cyc, 5);
        chk("conc_if_ready_cyc", if_rdy_cyc, 7);
        $display("txn conc: mem_ready@%0d if_re@%0d if_ready@%0d", mem_rdy_cyc, if_re_cyc, if_rdy_cyc);

        // Reset asserted during WAIT abandons the access
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        #1;
        chk("rst_wait_outputs", {if_ready, mem_ready, ram_re, ram_we, if_rdata, mem_rdata, ram_addr, ram_wdata}, 0);
        mem_req = 1'b0;
        last_if = '0; last_mem = '0;
        @(negedge clk);
        rst = 1'b1;
        mem_cnt = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (ram_re || ram_we || mem_ready || if_ready) mem_cnt++;
        end
        chk("post_rst_quiet", mem_cnt, 0);
        $display("txn rst: outputs cleared, quiet cycles checked");
        run_vec(9, vecs[1]);

        // Both requesters held: MEM dominates unless the guard is built
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h07FF;
        if_req = 1'b1; if_addr = 16'h0010;
        mem_cnt = 0; if_cnt = 0;
        for (int c = 0; c < 80 && if_cnt == 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready) mem_cnt++;
            if (if_ready) begin
                if_cnt++;
                chk("starve_if_rdata", if_rdata, 16'hABCD);
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_if_granted", if_cnt, 1);
        chk("starve_mem_before_if", mem_cnt, 4);
`else
        chk("starve_if_never", if_cnt, 0);
        chk("starve_mem_kept_going", (mem_cnt > 4) ? 1 : 0, 1);
`endif
        $display("txn starve: mem_ready=%0d if_ready=%0d", mem_cnt, if_cnt);
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
